// File: rtl/hack_mem_pkg.sv
// Shared constants, arbiter state type and address-legality helpers for the Hack memory arbiter.
package hack_mem_pkg;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 16;
  localparam int SCREEN_BASE = 16384;
  localparam int KBD_ADDR    = 24576;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  // Writes to the keyboard register and everything above it must never reach Memory.
  function automatic logic is_illegal_wr(input logic [ADDR_W-1:0] addr,
                                         input int kbd = KBD_ADDR);
    return (32'(addr) >= 32'(kbd));
  endfunction

  // The keyboard register itself is readable; only addresses beyond it are unmapped.
  function automatic logic is_unmapped(input logic [ADDR_W-1:0] addr,
                                       input int kbd = KBD_ADDR);
    return (32'(addr) > 32'(kbd));
  endfunction

endpackage

// File: rtl/hack_mem_arb_wait_ctr.sv
// Saturating count of cycles the scan-out port has been kept waiting; flags when the limit is reached.
module hack_mem_arb_wait_ctr
  import hack_mem_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_r;

  // Count waiting cycles, clear on every grant, hold at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == MAX_C);

endmodule

// File: rtl/hack_mem_arbiter.sv
// Two-port arbiter for the Hack Memory: CPU (A, read/write, priority) and scan-out (B, read-only, burst lock).
// Optional starvation guard for B is enabled by defining HACK_MEM_ARB_STARVE_GUARD_EN.
module hack_mem_arbiter
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W    = hack_mem_pkg::ADDR_W,
  parameter int DATA_W    = hack_mem_pkg::DATA_W,
  parameter int KBD_ADDR  = hack_mem_pkg::KBD_ADDR,
  parameter int BURST_MAX = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              err_addr
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  arb_state_t    state_r;
  arb_state_t    state_s;
  logic [BW-1:0] burst_r;
  logic [BW-1:0] burst_s;
  logic          gnt_a_s;
  logic          gnt_b_s;
  logic          force_b_s;
  logic          err_s;

`ifdef HACK_MEM_ARB_STARVE_GUARD_EN
  hack_mem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (b_req && !gnt_b_s),
    .clr    (gnt_b_s),
    .at_max (force_b_s)
  );
`else
  assign force_b_s = 1'b0;
`endif

  // Grant selection and next owner; a locked B burst outranks even the starvation override.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    state_s = IDLE;
    burst_s = '0;
    if (reset) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        OWN_B: begin
          if (b_req && b_lock && (burst_r < BURST_LIM)) begin
            gnt_b_s = 1'b1;
            burst_s = burst_r + BW'(1);
          end else if (b_req && force_b_s) begin
            gnt_b_s = 1'b1;
            burst_s = BW'(1);
          end else if (a_req) begin
            gnt_a_s = 1'b1;
          end else if (b_req) begin
            gnt_b_s = 1'b1;
            burst_s = BW'(1);
          end else begin
            gnt_a_s = 1'b0;
          end
        end
        IDLE, OWN_A: begin
          if (b_req && force_b_s) begin
            gnt_b_s = 1'b1;
            burst_s = BW'(1);
          end else if (a_req) begin
            gnt_a_s = 1'b1;
          end else if (b_req) begin
            gnt_b_s = 1'b1;
            burst_s = BW'(1);
          end else begin
            gnt_a_s = 1'b0;
          end
        end
        default: begin
          gnt_a_s = 1'b0;
        end
      endcase
      if (gnt_a_s) begin
        state_s = OWN_A;
      end else if (gnt_b_s) begin
        state_s = OWN_B;
      end else begin
        state_s = IDLE;
      end
    end
  end

  // Owner and burst length register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      burst_r <= '0;
    end else begin
      state_r <= state_s;
      burst_r <= burst_s;
    end
  end

  // Memory port mux; illegal writes keep the grant but never assert load.
  always_comb begin
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    err_s       = 1'b0;
    if (gnt_a_s) begin
      mem_address = a_addr;
      mem_in      = a_wdata;
      mem_load    = a_we && !is_illegal_wr(a_addr, KBD_ADDR);
      err_s       = a_we ? is_illegal_wr(a_addr, KBD_ADDR) : is_unmapped(a_addr, KBD_ADDR);
    end else if (gnt_b_s) begin
      mem_address = b_addr;
      err_s       = is_unmapped(b_addr, KBD_ADDR);
    end else begin
      mem_load = 1'b0;
    end
  end

  // Read return path: capture Memory at the end of the grant cycle, unmapped reads return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      err_addr <= 1'b0;
    end else begin
      a_rvalid <= gnt_a_s && !a_we;
      b_rvalid <= gnt_b_s;
      err_addr <= err_s;
      if (gnt_a_s && !a_we) begin
        a_rdata <= is_unmapped(a_addr, KBD_ADDR) ? '0 : mem_out;
      end else begin
        a_rdata <= a_rdata;
      end
      if (gnt_b_s) begin
        b_rdata <= is_unmapped(b_addr, KBD_ADDR) ? '0 : mem_out;
      end else begin
        b_rdata <= b_rdata;
      end
    end
  end

  assign a_gnt = gnt_a_s;
  assign b_gnt = gnt_b_s;

endmodule
